pwm_multi_ch_generator: RTL and testbench

- Parametrised successor to the single-channel button-controlled PWM generator.
- Drives NUM_CH independent PWM outputs from one shared period counter.
- Each channel has its own debounced increase/decrease buttons, saturating duty register and glitch-free period-boundary duty update.
- Sits between front-panel button inputs and PWM-driven loads (LED dimming, motor/DAC test stimulus).

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 44 ++++
 rtl/pwm_multi_ch_generator.sv | 118 +++++++++++
 tb/tb_pwm_multi_ch_generator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and duty saturation helper for the multi-channel PWM generator.
// Pure declarations: no latency, no flow control.
// Used by pwm_multi_ch_generator (optional PWM_CENTER_ALIGNED_EN lives in the top).
package pwm_pkg;

    localparam int PWM_PERIOD_DEF  = 10;
    localparam int PWM_CNT_W_DEF   = 8;
    localparam int PWM_DEB_CYC_DEF = 4;

    // 32-bit operands with a 33-bit sum cover any CNT_W up to 32 without wrap.
    function automatic logic [31:0] sat_add_sub(
        input logic [31:0] duty,
        input logic        inc,
        input logic        dec,
        input logic [31:0] step,
        input logic [31:0] max
    );
        logic [32:0] sum;
        logic [31:0] res;
        sum = {1'b0, duty} + {1'b0, step};
        res = duty;
        if (inc && !dec) begin
            res = (sum > {1'b0, max}) ? max : sum[31:0];
        end else if (dec && !inc) begin
            res = (duty >= step) ? duty - step : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge press pulse.
// Latency: 2+DEB_CYC cycles from raw press to one-cycle press pulse.
// Backpressure: none; a held button yields exactly one pulse.
module btn_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYC) + 1;

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [CW-1:0] stab_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            level    <= 1'b0;
            stab_cnt <= '0;
            press    <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            // stab_cnt counts consecutive samples that disagree with the accepted level
            if (sync_q2 == level) begin
                stab_cnt <= '0;
            end else if (stab_cnt == CW'(DEB_CYC - 1)) begin
                level    <= sync_q2;
                stab_cnt <= '0;
                press    <= sync_q2;
            end else begin
                stab_cnt <= stab_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multi_ch_generator.sv
// NUM_CH button-controlled PWM channels sharing one period counter; PWM_CENTER_ALIGNED_EN selects triangle counting.
// Latency: pwm_out registered one cycle after cnt; duty changes take effect at the next cnt==0.
// Backpressure: none; free-running outputs, buttons are sampled asynchronously.
module pwm_multi_ch_generator
    import pwm_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = PWM_CNT_W_DEF,
    parameter int PERIOD   = PWM_PERIOD_DEF,
    parameter int STEP     = 1,
    parameter int DUTY_RST = 5,
    parameter int DEB_CYC  = PWM_DEB_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       inc_btn,
    input  logic [NUM_CH-1:0]       dec_btn,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic [NUM_CH*CNT_W-1:0] duty,
    output logic                    period_start
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef PWM_CENTER_ALIGNED_EN
    logic up;
    logic up_nxt;

    always_comb begin
        cnt_nxt = cnt;
        up_nxt  = up;
        if (up) begin
            if (cnt == CNT_W'(PERIOD)) begin
                cnt_nxt = cnt - CNT_W'(1);
                up_nxt  = 1'b0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else begin
            cnt_nxt = cnt - CNT_W'(1);
        end
        if (cnt_nxt == '0) begin
            up_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up <= 1'b1;
        end else begin
            up <= up_nxt;
        end
    end
`else
    always_comb begin
        cnt_nxt = (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            period_start <= (cnt_nxt == '0);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             inc_p;
        logic             dec_p;
        logic             hi;
        logic             pwm_q;
        logic [CNT_W-1:0] shadow;
        logic [CNT_W-1:0] active;

        btn_debounce #(.DEB_CYC(DEB_CYC)) u_inc (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (inc_btn[i]),
            .press (inc_p)
        );

        btn_debounce #(.DEB_CYC(DEB_CYC)) u_dec (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (dec_btn[i]),
            .press (dec_p)
        );

`ifdef PWM_CENTER_ALIGNED_EN
        // cnt==duty counted once (up-slope) so the pulse is exactly 2*duty wide
        assign hi = (cnt < active) || (up && (cnt == active) && (active != '0));
`else
        assign hi = (cnt < active);
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= CNT_W'(DUTY_RST);
                active <= CNT_W'(DUTY_RST);
                pwm_q  <= 1'b0;
            end else begin
                shadow <= CNT_W'(sat_add_sub(32'(shadow), inc_p, dec_p, 32'(STEP), 32'(PERIOD)));
                if (cnt_nxt == '0) begin
                    active <= shadow;
                end
                pwm_q <= hi;
            end
        end

        assign pwm_out[i]                = pwm_q;
        assign duty[i*CNT_W +: CNT_W]    = active;
    end

endmodule

// File: tb/tb_pwm_multi_ch_generator.sv
// Self-checking bench for pwm_multi_ch_generator (edge-aligned build).
// Per-cycle scoreboard against a window/arithmetic model, plus table vectors and corner sequences.
module tb_pwm_multi_ch_generator;

    localparam int NCH  = 2;
    localparam int CW   = 8;
    localparam int P    = 10;
    localparam int STP  = 1;
    localparam int DRST = 5;
    localparam int DEB  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    inc_btn;
    logic [NCH-1:0]    dec_btn;
    logic [NCH-1:0]    pwm_out;
    logic [NCH*CW-1:0] duty;
    logic              period_start;

    always #5 clk = ~clk;

    pwm_multi_ch_generator #(
        .NUM_CH(NCH), .CNT_W(CW), .PERIOD(P), .STEP(STP), .DUTY_RST(DRST), .DEB_CYC(DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_btn      (inc_btn),
        .dec_btn      (dec_btn),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .period_start (period_start)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (values as seen after the most recent clock edge)
    int m_cnt;
    int m_shadow [NCH];
    int m_active [NCH];
    bit m_pwm    [NCH];
    bit m_ps;
    bit m_pls    [2*NCH];
    bit m_lvl    [2*NCH];
    bit m_hist   [2*NCH][8];

    int hi [NCH];
    int ps_cnt;

    typedef struct {
        logic [NCH-1:0] inc;
        logic [NCH-1:0] dec;
        int             hold;
        int             d0;
        int             d1;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_ps  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = DRST;
            m_active[i] = DRST;
            m_pwm[i]    = 1'b0;
        end
        for (int b = 0; b < 2*NCH; b++) begin
            m_pls[b] = 1'b0;
            m_lvl[b] = 1'b0;
            for (int j = 0; j < 8; j++) m_hist[b][j] = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour
    task automatic model_step();
        int nc;
        bit raw;
        bit eq;
        bit np [2*NCH];
        nc = (m_cnt + 1) % P;
        for (int i = 0; i < NCH; i++) begin
            m_pwm[i] = (m_cnt < m_active[i]);
            if (nc == 0) m_active[i] = m_shadow[i];
            if (m_pls[i] && !m_pls[NCH+i])
                m_shadow[i] = (m_shadow[i] + STP > P) ? P : m_shadow[i] + STP;
            else if (m_pls[NCH+i] && !m_pls[i])
                m_shadow[i] = (m_shadow[i] < STP) ? 0 : m_shadow[i] - STP;
        end
        for (int b = 0; b < 2*NCH; b++) begin
            raw = (b < NCH) ? inc_btn[b] : dec_btn[b-NCH];
            // hist[1..DEB] are the synchronised samples seen over the last DEB edges
            eq = 1'b1;
            for (int j = 2; j <= DEB; j++) if (m_hist[b][j] != m_hist[b][1]) eq = 1'b0;
            np[b] = 1'b0;
            if (eq && (m_hist[b][1] != m_lvl[b])) begin
                m_lvl[b] = m_hist[b][1];
                np[b]    = m_lvl[b];
            end
            for (int j = 7; j >= 1; j--) m_hist[b][j] = m_hist[b][j-1];
            m_hist[b][0] = raw;
        end
        for (int b = 0; b < 2*NCH; b++) m_pls[b] = np[b];
        m_cnt = nc;
        m_ps  = (nc == 0);
    endtask

    task automatic tick();
        logic [NCH*CW-1:0] e_duty;
        logic [NCH-1:0]    e_pwm;
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            e_duty[i*CW +: CW] = CW'(m_active[i]);
            e_pwm[i]           = m_pwm[i];
            hi[i]             += int'(pwm_out[i]);
        end
        ps_cnt += int'(period_start);
        check("pwm_out", 32'(pwm_out), 32'(e_pwm));
        check("duty", 32'(duty), 32'(e_duty));
        check("period_start", 32'(period_start), 32'(m_ps));
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        ps_cnt = 0;
    endtask

    task automatic press(input logic [NCH-1:0] i_m, input logic [NCH-1:0] d_m, input int n);
        for (int k = 0; k < n; k++) begin
            inc_btn = i_m;
            dec_btn = d_m;
            repeat (8) tick();
            inc_btn = '0;
            dec_btn = '0;
            repeat (10) tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        tbl[0] = '{inc: 2'b01, dec: 2'b00, hold: 10, d0: 6, d1: 5};
        tbl[1] = '{inc: 2'b00, dec: 2'b10, hold: 10, d0: 6, d1: 4};
        tbl[2] = '{inc: 2'b01, dec: 2'b01, hold: 10, d0: 6, d1: 4};
        tbl[3] = '{inc: 2'b11, dec: 2'b00, hold: 10, d0: 7, d1: 5};
        tbl[4] = '{inc: 2'b00, dec: 2'b11, hold: 10, d0: 6, d1: 4};

        rst_n   = 1'b0;
        inc_btn = '0;
        dec_btn = '0;
        model_reset();
        #12;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_duty", 32'(duty), 32'h0505);

        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (30) tick();
        check("init_hi0", hi[0], 15);
        check("init_hi1", hi[1], 15);
        check("init_period_starts", ps_cnt, 3);

        for (int k = 0; k < 5; k++) begin
            inc_btn = tbl[k].inc;
            dec_btn = tbl[k].dec;
            repeat (tbl[k].hold) tick();
            inc_btn = '0;
            dec_btn = '0;
            repeat (30) tick();
            clear_counts();
            repeat (20) tick();
            check("tbl_duty0", 32'(duty[0 +: CW]), tbl[k].d0);
            check("tbl_duty1", 32'(duty[CW +: CW]), tbl[k].d1);
            check("tbl_hi0", hi[0], 2 * tbl[k].d0);
            check("tbl_hi1", hi[1], 2 * tbl[k].d1);
        end

        // Bouncing button: level never stable for DEB samples
        for (int k = 0; k < 10; k++) begin
            inc_btn[1] = ~inc_btn[1];
            repeat (2) tick();
        end
        inc_btn = '0;
        repeat (30) tick();
        check("bounce_duty1", 32'(duty[CW +: CW]), 32'd4);

        // Saturation high then low
        press(2'b01, 2'b00, 6);
        repeat (10) tick();
        clear_counts();
        repeat (20) tick();
        check("sat_hi_duty0", 32'(duty[0 +: CW]), 32'd10);
        check("sat_hi_pwm0", hi[0], 20);
        press(2'b00, 2'b01, 11);
        repeat (10) tick();
        clear_counts();
        repeat (20) tick();
        check("sat_lo_duty0", 32'(duty[0 +: CW]), 32'd0);
        check("sat_lo_pwm0", hi[0], 0);

        // Mid-period reset at cnt==3 with duty[0]==8
        press(2'b01, 2'b00, 8);
        repeat (20) tick();
        check("pre_rst_duty0", 32'(duty[0 +: CW]), 32'd8);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt == 3) found = 1'b1;
            else tick();
        end
        check("wait_cnt3", 32'(found), 32'd1);
        check("pre_rst_pwm0", 32'(pwm_out[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm_out", 32'(pwm_out), 32'd0);
        check("async_rst_duty", 32'(duty), 32'h0505);
        check("async_rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_counts();
        repeat (30) tick();
        check("post_rst_hi0", hi[0], 15);
        check("post_rst_hi1", hi[1], 15);
        check("post_rst_period_starts", ps_cnt, 3);

        // Randomised button activity against the model
        for (int k = 0; k < 60; k++) begin
            inc_btn = NCH'($urandom_range(0, 3));
            dec_btn = NCH'($urandom_range(0, 3));
            repeat ($urandom_range(1, 12)) tick();
        end
        inc_btn = '0;
        dec_btn = '0;
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
